hockey_display: RTL and testbench

Display back-end for the air-hockey machine. It consumes the game controller's outputs: puck coordinates, scores and state code. It renders them on eight time-multiplexed seven-segment digits, the player LEDs and a 5-LED Y indicator. Inputs are captured into a pending buffer on an update strobe and committed only at frame boundaries, so a scan frame never mixes old and new game data.

---
 rtl/hockey_pkg.sv | 82 ++++++++
 rtl/hockey_glyph.sv | 32 +++
 rtl/hockey_display.sv | 141 ++++++++++++++
 tb/tb_hockey_display.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hockey_pkg.sv
// Shared game codes, glyph constants and the game-state payload used by
// the air-hockey controller and its display back-end.
package hockey_pkg;

  localparam int unsigned MODE_W  = 4;
  localparam int unsigned COORD_W = 3;
  localparam int unsigned SCORE_W = 2;
  localparam int unsigned SEG_W   = 7;

  localparam logic [MODE_W-1:0] MODE_IDLE      = 4'd0;
  localparam logic [MODE_W-1:0] MODE_DISPLAY   = 4'd1;
  localparam logic [MODE_W-1:0] MODE_HIT_A     = 4'd2;
  localparam logic [MODE_W-1:0] MODE_HIT_B     = 4'd3;
  localparam logic [MODE_W-1:0] MODE_SEND_A    = 4'd4;
  localparam logic [MODE_W-1:0] MODE_SEND_B    = 4'd5;
  localparam logic [MODE_W-1:0] MODE_RESP_A    = 4'd6;
  localparam logic [MODE_W-1:0] MODE_RESP_B    = 4'd7;
  localparam logic [MODE_W-1:0] MODE_GOAL_A    = 4'd8;
  localparam logic [MODE_W-1:0] MODE_GOAL_B    = 4'd9;
  localparam logic [MODE_W-1:0] MODE_GAME_OVER = 4'd10;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] GLYPH_0     = 7'h40;
  localparam logic [SEG_W-1:0] GLYPH_1     = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_2     = 7'h24;
  localparam logic [SEG_W-1:0] GLYPH_3     = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_A     = 7'h08;
  localparam logic [SEG_W-1:0] GLYPH_B     = 7'h03;
  localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] PUCK_D      = 7'h77;
  localparam logic [SEG_W-1:0] PUCK_C      = 7'h7B;
  localparam logic [SEG_W-1:0] PUCK_G      = 7'h3F;
  localparam logic [SEG_W-1:0] PUCK_B      = 7'h7D;
  localparam logic [SEG_W-1:0] PUCK_A      = 7'h7E;

  typedef struct packed {
    logic [MODE_W-1:0]  mode;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
  } game_t;

  function automatic logic is_play(input logic [MODE_W-1:0] m);
    return m inside {MODE_HIT_A, MODE_HIT_B, MODE_SEND_A, MODE_SEND_B,
                     MODE_RESP_A, MODE_RESP_B};
  endfunction

  function automatic logic is_score(input logic [MODE_W-1:0] m);
    return m inside {MODE_DISPLAY, MODE_GOAL_A, MODE_GOAL_B, MODE_GAME_OVER};
  endfunction

  function automatic logic is_goal(input logic [MODE_W-1:0] m);
    return (m == MODE_GOAL_A) || (m == MODE_GOAL_B);
  endfunction

  function automatic logic [SEG_W-1:0] score_glyph(input logic [SCORE_W-1:0] s);
    logic [SEG_W-1:0] g;
    case (s)
      2'd0:    g = GLYPH_0;
      2'd1:    g = GLYPH_1;
      2'd2:    g = GLYPH_2;
      default: g = GLYPH_3;
    endcase
    return g;
  endfunction

  function automatic logic [SEG_W-1:0] puck_glyph(input logic [COORD_W-1:0] y);
    logic [SEG_W-1:0] g;
    case (y)
      3'd0:    g = PUCK_D;
      3'd1:    g = PUCK_C;
      3'd2:    g = PUCK_G;
      3'd3:    g = PUCK_B;
      3'd4:    g = PUCK_A;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hockey_glyph.sv
// Combinational segment decoder: picks the glyph for one digit slot from
// the committed game state and the blink phase.
module hockey_glyph
  import hockey_pkg::*;
(
  input  logic [2:0]       digit_i,
  input  game_t            game_i,
  input  logic             blink_off_i,
  output logic [SEG_W-1:0] seg_c_o
);

  always_comb begin
    seg_c_o = GLYPH_BLANK;
    if (blink_off_i && is_goal(game_i.mode)) begin
      seg_c_o = GLYPH_BLANK;
    end else if (game_i.mode == MODE_IDLE) begin
      seg_c_o = GLYPH_DASH;
    end else if (is_play(game_i.mode)) begin
      if (digit_i == game_i.x) seg_c_o = puck_glyph(game_i.y);
    end else if (is_score(game_i.mode)) begin
      case (digit_i)
        3'd7:       seg_c_o = GLYPH_A;
        3'd6:       seg_c_o = score_glyph(game_i.score_a);
        3'd4, 3'd3: seg_c_o = GLYPH_DASH;
        3'd1:       seg_c_o = score_glyph(game_i.score_b);
        3'd0:       seg_c_o = GLYPH_B;
        default:    seg_c_o = GLYPH_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/hockey_display.sv
// Air-hockey display back-end: double-buffered game state, 8-digit scan,
// blink timing and registered LED/segment drive.
module hockey_display
  import hockey_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 16,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               update,
  input  logic [COORD_W-1:0] x_coord,
  input  logic [COORD_W-1:0] y_coord,
  input  logic [SCORE_W-1:0] score_a,
  input  logic [SCORE_W-1:0] score_b,
  input  logic [MODE_W-1:0]  mode,
  output logic [7:0]         an,
  output logic [SEG_W-1:0]   seg,
  output logic               led_a,
  output logic               led_b,
  output logic [4:0]         ledx,
  output logic               frame_done
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic [2:0]         digit_q, digit_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;
  game_t              pend_q, pend_d;
  game_t              act_q, act_d;

  logic [7:0]         an_q, an_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               led_a_q, led_a_d;
  logic               led_b_q, led_b_d;
  logic [4:0]         ledx_q, ledx_d;
  logic               frame_done_q, frame_done_d;

  logic               scan_wrap_c, boundary_c, blink_wrap_c, goal_off_c;
  logic [SEG_W-1:0]   glyph_c;

  hockey_glyph u_glyph (
    .digit_i     (digit_q),
    .game_i      (act_q),
    .blink_off_i (blink_off_q),
    .seg_c_o     (glyph_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q       <= '0;
      digit_q      <= '0;
      blink_cnt_q  <= '0;
      blink_off_q  <= 1'b0;
      pend_q       <= '0;
      act_q        <= '0;
      an_q         <= 8'hFF;
      seg_q        <= GLYPH_BLANK;
      led_a_q      <= 1'b0;
      led_b_q      <= 1'b0;
      ledx_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      scan_q       <= scan_d;
      digit_q      <= digit_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_off_q  <= blink_off_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      led_a_q      <= led_a_d;
      led_b_q      <= led_b_d;
      ledx_q       <= ledx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Scan, buffering and blink timing; commit only on the digit 7 -> 0 wrap
  always_comb begin
    scan_wrap_c  = (scan_q == SCAN_W'(SCAN_DIV - 1));
    boundary_c   = scan_wrap_c && (digit_q == 3'd7);
    blink_wrap_c = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

    scan_d  = scan_wrap_c ? '0 : scan_q + SCAN_W'(1);
    digit_d = scan_wrap_c ? digit_q + 3'd1 : digit_q;

    pend_d = pend_q;
    if (update) begin
      pend_d.mode    = mode;
      pend_d.x       = x_coord;
      pend_d.y       = y_coord;
      pend_d.score_a = score_a;
      pend_d.score_b = score_b;
    end
    act_d = boundary_c ? pend_q : act_q;

    blink_cnt_d = blink_wrap_c ? '0 : blink_cnt_q + BLINK_W'(1);
    blink_off_d = blink_wrap_c ? ~blink_off_q : blink_off_q;
    if (boundary_c && (pend_q.mode != act_q.mode)) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end
  end

  // Output drive from the current digit slot and committed state
  always_comb begin
    goal_off_c   = blink_off_q && is_goal(act_q.mode);
    an_d         = goal_off_c ? 8'hFF : ~(8'd1 << digit_q);
    seg_d        = glyph_c;
    frame_done_d = boundary_c;
    ledx_d       = '0;
    led_a_d      = 1'b0;
    led_b_d      = 1'b0;

    if (is_play(act_q.mode) && (act_q.y <= 3'd4)) ledx_d = 5'd1 << act_q.y;

    case (act_q.mode)
      MODE_HIT_A, MODE_RESP_A: led_a_d = 1'b1;
      MODE_HIT_B, MODE_RESP_B: led_b_d = 1'b1;
      MODE_GOAL_A:             led_a_d = ~blink_off_q;
      MODE_GOAL_B:             led_b_d = ~blink_off_q;
      MODE_GAME_OVER: begin
        led_a_d = (act_q.score_a >= act_q.score_b);
        led_b_d = (act_q.score_b >= act_q.score_a);
      end
      default: ;
    endcase
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign led_a      = led_a_q;
  assign led_b      = led_b_q;
  assign ledx       = ledx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hockey_display.sv
// Scoreboard bench for hockey_display: stimulus predicts each frame's
// content from a frame-level game model; a monitor checks every scan slot.
module tb_hockey_display;

  localparam int SD = 4;
  localparam int BD = 16;
  localparam int F  = 8 * SD;
  localparam int NF = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       update = 1'b0;
  logic [2:0] x_coord = '0, y_coord = '0;
  logic [1:0] score_a = '0, score_b = '0;
  logic [3:0] mode = '0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       led_a, led_b, frame_done;
  logic [4:0] ledx;

  hockey_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .update(update), .x_coord(x_coord), .y_coord(y_coord),
    .score_a(score_a), .score_b(score_b), .mode(mode), .an(an), .seg(seg),
    .led_a(led_a), .led_b(led_b), .ledx(ledx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Cycle stamp: value k after the k-th rising edge since reset release
  int unsigned cyc;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  typedef struct {
    int mode, x, y, sa, sb;
    int unsigned origin;
    int unsigned boundary;
  } exp_t;

  typedef struct {
    int unsigned at_edge;
    int m, x, y, sa, sb;
  } dir_t;

  exp_t q[$];
  int   n_pass = 0, n_total = 0, n_fail = 0;
  bit   mon_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] score_seg(input int s);
    logic [6:0] t[4] = '{7'h40, 7'h79, 7'h24, 7'h30};
    return t[s];
  endfunction

  function automatic logic [6:0] puck_seg(input int y);
    logic [6:0] t[8] = '{7'h77, 7'h7B, 7'h3F, 7'h7D, 7'h7E, 7'h7F, 7'h7F, 7'h7F};
    return t[y];
  endfunction

  // What the display should show in digit slot d for game state e
  function automatic logic [21:0] expect_slot(input exp_t e, input int d, input bit off);
    bit play  = (e.mode >= 2) && (e.mode <= 7);
    bit score = (e.mode == 1) || ((e.mode >= 8) && (e.mode <= 10));
    bit dark  = ((e.mode == 8) || (e.mode == 9)) && off;
    logic [7:0] a = 8'hFF;
    logic [6:0] s = 7'h7F;
    logic       la, lb;
    logic [4:0] lx = '0;
    if (!dark) a[d] = 1'b0;
    if (dark)             s = 7'h7F;
    else if (e.mode == 0) s = 7'h3F;
    else if (play)        s = (d == e.x) ? puck_seg(e.y) : 7'h7F;
    else if (score) begin
      case (d)
        7:       s = 7'h08;
        6:       s = score_seg(e.sa);
        4, 3:    s = 7'h3F;
        1:       s = score_seg(e.sb);
        0:       s = 7'h03;
        default: s = 7'h7F;
      endcase
    end
    la = (e.mode == 2) || (e.mode == 6) || (e.mode == 8 && !off) || (e.mode == 10 && e.sa >= e.sb);
    lb = (e.mode == 3) || (e.mode == 7) || (e.mode == 9 && !off) || (e.mode == 10 && e.sb >= e.sa);
    if (play && e.y <= 4) lx[e.y] = 1'b1;
    return {a, s, la, lb, lx};
  endfunction

  // Monitor: one expected record per committed frame, checked slot by slot
  initial begin : monitor
    exp_t e;
    bit   found = 1'b0;
    for (int i = 0; i < 4 * F + 10; i++) begin
      @(negedge clk);
      if (!rst && frame_done) begin found = 1'b1; break; end
    end
    check("first_frame_done", 32'(found), 32'd1);
    if (found) begin
      for (int fr = 0; fr < NF; fr++) begin
        check("queue_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() == 0) break;
        e = q.pop_front();
        check("frame_boundary", cyc, e.boundary);
        for (int i = 1; i <= F; i++) begin
          int unsigned n;
          bit off;
          @(negedge clk);
          n   = cyc;
          off = (((n - 1 - e.origin) / BD) % 2) == 1;
          check("slot", 32'({an, seg, led_a, led_b, ledx, frame_done}),
                32'({expect_slot(e, (i - 1) / SD, off), (i == F)}));
        end
      end
    end
    mon_done = 1'b1;
  end

  task automatic drive(input int m, input int x, input int y, input int sa, input int sb,
                       inout exp_t pend);
    update  = 1'b1;
    mode    = 4'(m);
    x_coord = 3'(x);
    y_coord = 3'(y);
    score_a = 2'(sa);
    score_b = 2'(sb);
    pend.mode = m; pend.x = x; pend.y = y; pend.sa = sa; pend.sb = sb;
  endtask

  initial begin : stimulus
    dir_t        dirs[$];
    exp_t        pend, e;
    int          act_mode = 0, pushed = 0, di = 0;
    int unsigned origin = 0, n;

    pend = '{default: 0};
    dirs.push_back('{F + 5,       4, 5, 3, 0, 0});
    dirs.push_back('{2 * F + 3,   4, 2, 1, 1, 0});
    dirs.push_back('{2 * F + 20,  4, 6, 1, 1, 0});
    dirs.push_back('{4 * F,       2, 3, 6, 0, 0});
    dirs.push_back('{6 * F + 7,   8, 0, 0, 2, 1});
    dirs.push_back('{10 * F + 9, 10, 0, 0, 3, 1});
    dirs.push_back('{12 * F + 1, 12, 4, 2, 1, 1});
    dirs.push_back('{13 * F + 10,10, 0, 0, 2, 2});
    dirs.push_back('{14 * F + 4,  9, 1, 1, 0, 3});
    dirs.push_back('{17 * F + 31, 0, 0, 0, 0, 0});
    dirs.push_back('{18 * F + 2,  7, 0, 4, 1, 2});

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({an, seg, led_a, led_b, ledx, frame_done}),
          32'({8'hFF, 7'h7F, 1'b0, 1'b0, 5'b0, 1'b0}));
    rst = 1'b0;
    @(negedge clk);
    check("first_slot", 32'({an, seg, led_a, led_b, ledx, frame_done}),
          32'({8'hFE, 7'h3F, 1'b0, 1'b0, 5'b0, 1'b0}));

    while (pushed < NF) begin
      n = cyc + 1;
      if (n % F == 0) begin
        e = pend;
        if (e.mode != act_mode) begin origin = n; act_mode = e.mode; end
        e.origin   = origin;
        e.boundary = n;
        q.push_back(e);
        pushed++;
      end
      if (di < dirs.size() && dirs[di].at_edge == n) begin
        drive(dirs[di].m, dirs[di].x, dirs[di].y, dirs[di].sa, dirs[di].sb, pend);
        di++;
      end else if (n > 20 * F && $urandom_range(39) == 0) begin
        int m = ($urandom_range(2) == 0) ? int'($urandom_range(8, 10)) : int'($urandom_range(15));
        drive(m, $urandom_range(7), $urandom_range(7), $urandom_range(3), $urandom_range(3), pend);
      end else begin
        update  = 1'b0;
        mode    = 4'($urandom_range(15));
        x_coord = 3'($urandom_range(7));
        y_coord = 3'($urandom_range(7));
        score_a = 2'($urandom_range(3));
        score_b = 2'($urandom_range(3));
      end
      @(negedge clk);
    end
    update = 1'b0;

    for (int i = 0; i < 4 * F && !mon_done; i++) @(negedge clk);
    check("monitor_done", 32'(mon_done), 32'd1);

    // Pending holds a play frame, then an async reset lands mid-cycle
    update = 1'b1; mode = 4'd3; x_coord = 3'd0; y_coord = 3'd0;
    @(negedge clk);
    update = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", 32'({an, seg, led_a, led_b, ledx, frame_done}),
             32'({8'hFF, 7'h7F, 1'b0, 1'b0, 5'b0, 1'b0}));
    @(negedge clk);
    rst = 1'b0;
    repeat (F) @(negedge clk);
    check("frame_done_after_reset", 32'(frame_done), 32'd1);
    @(negedge clk);
    check("pending_discarded", 32'({an, seg, ledx}), 32'({8'hFE, 7'h3F, 5'b0}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
